// File: rtl/hsv_core_commit_order.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_commit_order
// Description : In-order commit stage. Several execution units present
//               results tagged with the issue-order token. Only the result
//               whose token equals the expected token may commit. Among
//               several matching units the lowest index wins. The winner is
//               loaded into a single output register that holds its contents
//               while the downstream stage stalls. The expected token
//               advances by one per commit and wraps modulo 2^TOKEN_W.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature:
//   HSV_COMMIT_TIMEOUT_EN - compiles in a saturating watchdog counter that
//                           raises a sticky timeout_o flag when results wait
//                           TIMEOUT cycles without a commit. When the macro
//                           is undefined, timeout_o is tied low and TIMEOUT
//                           is ignored.
// ----------------------------------------------------------------------------
// Ports:
//   clk_core          in   core clock, rising edge
//   rst_core_n        in   asynchronous active-low reset
//   flush_req         in   synchronous pipeline flush (dominates grant)
//   unit_valid_i      in   per-unit result valid
//   unit_token_i      in   per-unit issue token, slice i = unit i
//   unit_rd_addr_i    in   per-unit destination register
//   unit_rd_we_i      in   per-unit writeback enable
//   unit_result_i     in   per-unit result word
//   unit_ready_o      out  one-hot of unit accepted this cycle
//   commit_stall_i    in   downstream cannot take the commit output
//   commit_valid_o    out  commit output valid
//   commit_unit_o     out  index of committed unit
//   commit_rd_addr_o  out  committed destination register
//   commit_data_o     out  committed result word
//   commit_mask_o     out  one-hot of committed rd (0 for x0 / no write)
//   expected_token_o  out  next token allowed to commit
//   timeout_o         out  sticky watchdog flag
// ============================================================================
module hsv_core_commit_order #(
    parameter int NUM_UNITS = 5,
    parameter int TOKEN_W   = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk_core,
    input  logic                         rst_core_n,
    input  logic                         flush_req,
    input  logic [NUM_UNITS-1:0]         unit_valid_i,
    input  logic [NUM_UNITS*TOKEN_W-1:0] unit_token_i,
    input  logic [NUM_UNITS*5-1:0]       unit_rd_addr_i,
    input  logic [NUM_UNITS-1:0]         unit_rd_we_i,
    input  logic [NUM_UNITS*32-1:0]      unit_result_i,
    output logic [NUM_UNITS-1:0]         unit_ready_o,
    input  logic                         commit_stall_i,
    output logic                         commit_valid_o,
    output logic [$clog2(NUM_UNITS)-1:0] commit_unit_o,
    output logic [4:0]                   commit_rd_addr_o,
    output logic [31:0]                  commit_data_o,
    output logic [31:0]                  commit_mask_o,
    output logic [TOKEN_W-1:0]           expected_token_o,
    output logic                         timeout_o
);

    localparam int UNIT_W = $clog2(NUM_UNITS);

    // ------------------------------------------------------------------
    // Per-unit slices of the flattened input buses
    // ------------------------------------------------------------------
    logic [TOKEN_W-1:0] w_token [NUM_UNITS];
    logic [4:0]         w_rd    [NUM_UNITS];
    logic [31:0]        w_data  [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_match;

    // State registers
    logic               commit_valid_q, commit_valid_d;
    logic [UNIT_W-1:0]  commit_unit_q,  commit_unit_d;
    logic [4:0]         commit_rd_q,    commit_rd_d;
    logic               commit_we_q,    commit_we_d;
    logic [31:0]        commit_data_q,  commit_data_d;
    logic [TOKEN_W-1:0] expected_q,     expected_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign w_token[gi] = unit_token_i[gi*TOKEN_W +: TOKEN_W];
            assign w_rd[gi]    = unit_rd_addr_i[gi*5 +: 5];
            assign w_data[gi]  = unit_result_i[gi*32 +: 32];
            assign w_match[gi] = unit_valid_i[gi] && (w_token[gi] == expected_q);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lowest-index match selection. Scanning from the top down and letting
    // each later (lower) match overwrite leaves the lowest index selected.
    // ------------------------------------------------------------------
    logic                 w_any;
    logic [UNIT_W-1:0]    w_win;
    logic [NUM_UNITS-1:0] w_onehot;
    logic [4:0]           w_sel_rd;
    logic                 w_sel_we;
    logic [31:0]          w_sel_data;

    always_comb begin
        w_any      = 1'b0;
        w_win      = '0;
        w_onehot   = '0;
        w_sel_rd   = '0;
        w_sel_we   = 1'b0;
        w_sel_data = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_any       = 1'b1;
                w_win       = UNIT_W'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_sel_rd    = w_rd[i];
                w_sel_we    = unit_rd_we_i[i];
                w_sel_data  = w_data[i];
            end
        end
    end

    // The output register can take a new commit when it is empty or when
    // its current contents are consumed this cycle.
    logic w_out_free;
    logic w_grant;

    assign w_out_free = !commit_valid_q || !commit_stall_i;
    assign w_grant    = w_any && w_out_free && !flush_req;

    // Reset gates the handshake: while reset is held the registers read as
    // empty/expected=0, which would otherwise let a token-0 result through.
    assign unit_ready_o = (w_grant && rst_core_n) ? w_onehot : '0;

    // ------------------------------------------------------------------
    // Output register / expected-token next state
    // ------------------------------------------------------------------
    always_comb begin
        commit_valid_d = commit_valid_q;
        commit_unit_d  = commit_unit_q;
        commit_rd_d    = commit_rd_q;
        commit_we_d    = commit_we_q;
        commit_data_d  = commit_data_q;
        expected_d     = expected_q;

        if (flush_req) begin
            commit_valid_d = 1'b0;
            expected_d     = '0;
        end else if (w_grant) begin
            commit_valid_d = 1'b1;
            commit_unit_d  = w_win;
            commit_rd_d    = w_sel_rd;
            commit_we_d    = w_sel_we;
            commit_data_d  = w_sel_data;
            expected_d     = expected_q + 1'b1;   // natural wrap at 2^TOKEN_W
        end else if (w_out_free) begin
            commit_valid_d = 1'b0;
        end
        // Otherwise stalled with valid output: hold everything.
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            commit_valid_q <= 1'b0;
            commit_unit_q  <= '0;
            commit_rd_q    <= '0;
            commit_we_q    <= 1'b0;
            commit_data_q  <= '0;
            expected_q     <= '0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_unit_q  <= commit_unit_d;
            commit_rd_q    <= commit_rd_d;
            commit_we_q    <= commit_we_d;
            commit_data_q  <= commit_data_d;
            expected_q     <= expected_d;
        end
    end

    assign commit_valid_o   = commit_valid_q;
    assign commit_unit_o    = commit_unit_q;
    assign commit_rd_addr_o = commit_rd_q;
    assign commit_data_o    = commit_data_q;
    assign expected_token_o = expected_q;

    // Register x0 is never written, so it never appears in the mask.
    assign commit_mask_o = (commit_valid_q && commit_we_q && (commit_rd_q != 5'd0))
                         ? (32'd1 << commit_rd_q) : 32'd0;

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef HSV_COMMIT_TIMEOUT_EN
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             timeout_q,  timeout_d;

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        timeout_d  = timeout_q;
        if (flush_req || w_grant) begin
            wdog_cnt_d = '0;
        end else if ((|unit_valid_i) && !commit_stall_i && (wdog_cnt_q != C_LIMIT)) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
        // Flag rises on the edge where the count reaches the limit and
        // stays set until a flush, regardless of later commits.
        if (flush_req) begin
            timeout_d = 1'b0;
        end else if (wdog_cnt_d == C_LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire
